// File: rtl/vga_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_sink
// Purpose  : Stores (x, y, color) pixel writes into an on-chip frame buffer
//            and continuously scans the buffer out as a VGA raster with
//            8-bit DAC outputs. The buffer is cleared to a background color
//            after reset before any writes are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_sink #(
    parameter int         XSCREEN  = 640,
    parameter int         YSCREEN  = 480,
    parameter logic [8:0] BG_COLOR = 9'b111_111_111,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [8:0]  pix_color,
    input  logic        pix_write,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int              c_depth     = XSCREEN * YSCREEN;
    localparam int              c_aw        = $clog2(c_depth);
    localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_depth - 1);
    localparam logic [9:0]      c_x         = 10'(XSCREEN);
    localparam logic [9:0]      c_y         = 10'(YSCREEN);
    localparam logic [9:0]      c_h_last    = 10'(XSCREEN + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]      c_v_last    = 10'(YSCREEN + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]      c_hs_first  = 10'(XSCREEN + H_FP);
    localparam logic [9:0]      c_hs_last   = 10'(XSCREEN + H_FP + H_SYNC - 1);
    localparam logic [9:0]      c_vs_first  = 10'(YSCREEN + V_FP);
    localparam logic [9:0]      c_vs_last   = 10'(YSCREEN + V_FP + V_SYNC - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_aw-1:0] r_clr_addr;
    logic            r_we;
    logic [c_aw-1:0] r_waddr;
    logic [8:0]      r_wdata;
    logic [15:0]     r_drop;

    logic [8:0]      r_mem [0:c_depth-1];
    logic [8:0]      r_rd_data;

    logic            r_pix_en;
    logic            r_vga_clk;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;

    logic [c_aw-1:0] r_rd_addr;
    logic            r_vis1, r_hs1, r_vs1;
    logic            r_vis2, r_hs2, r_vs2;
    logic            r_hs_o, r_vs_o, r_blank_n_o;
    logic [7:0]      r_r_o, r_g_o, r_b_o;

    logic            w_in_range;
    logic [c_aw-1:0] w_pix_addr;
    logic            w_visible;
    logic            w_hs_n;
    logic            w_vs_n;
    logic [c_aw-1:0] w_scan_addr;

    // Requested pixel address and its range check (address only meaningful in range)
    assign w_in_range = (pix_x < c_x) && ({1'b0, pix_y} < c_y);
    assign w_pix_addr = c_aw'(pix_y) * c_aw'(XSCREEN) + c_aw'(pix_x);

    // Write side: clear sweep after reset, then registered acceptance of pixel writes
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_drop     <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_clr_addr;
                    r_wdata <= BG_COLOR;
                    if (r_clr_addr == c_last_addr) begin
                        r_state    <= ST_RUN;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_aw'(1);
                    end
                end
                ST_RUN: begin
                    r_we    <= pix_write && w_in_range;
                    r_waddr <= w_pix_addr;
                    r_wdata <= pix_color;
                    if (pix_write && !w_in_range && (r_drop != 16'hFFFF)) begin
                        r_drop <= r_drop + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer: one write and one registered read per clock, read returns old data on collision
    always_ff @(posedge Clock) begin
        if (r_we) begin
            r_mem[r_waddr] <= r_wdata;
        end
        r_rd_data <= r_mem[r_rd_addr];
    end

    // Raster counters advance on every other clock (pixel clock enable)
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_pix_en  <= ~r_pix_en;
            r_vga_clk <= r_pix_en;
            if (r_pix_en) begin
                if (r_h_cnt == c_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    assign w_visible   = (r_h_cnt < c_x) && (r_v_cnt < c_y);
    assign w_hs_n      = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
    assign w_vs_n      = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));
    assign w_scan_addr = c_aw'(r_v_cnt) * c_aw'(XSCREEN) + c_aw'(r_h_cnt);

    // Three-stage scan pipeline: address/timing, RAM data, registered DAC outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_rd_addr   <= '0;
            r_vis1      <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_vis2      <= 1'b0;
            r_hs2       <= 1'b1;
            r_vs2       <= 1'b1;
            r_hs_o      <= 1'b1;
            r_vs_o      <= 1'b1;
            r_blank_n_o <= 1'b0;
            r_r_o       <= '0;
            r_g_o       <= '0;
            r_b_o       <= '0;
        end else begin
            r_rd_addr   <= w_visible ? w_scan_addr : '0;
            r_vis1      <= w_visible;
            r_hs1       <= w_hs_n;
            r_vs1       <= w_vs_n;
            r_vis2      <= r_vis1;
            r_hs2       <= r_hs1;
            r_vs2       <= r_vs1;
            r_hs_o      <= r_hs2;
            r_vs_o      <= r_vs2;
            r_blank_n_o <= r_vis2;
            if (r_vis2) begin
                r_r_o <= {r_rd_data[8:6], r_rd_data[8:6], r_rd_data[8:7]};
                r_g_o <= {r_rd_data[5:3], r_rd_data[5:3], r_rd_data[5:4]};
                r_b_o <= {r_rd_data[2:0], r_rd_data[2:0], r_rd_data[2:1]};
            end else begin
                r_r_o <= '0;
                r_g_o <= '0;
                r_b_o <= '0;
            end
        end
    end

    assign busy        = (r_state == ST_CLEAR);
    assign drop_count  = r_drop;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs_o;
    assign VGA_VS      = r_vs_o;
    assign VGA_BLANK_N = r_blank_n_o;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_r_o;
    assign VGA_G       = r_g_o;
    assign VGA_B       = r_b_o;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_sink
// Purpose  : Self-checking bench for vga_frame_sink using a reduced screen
//            geometry; a scoreboard queues expected VGA outputs from a raster
//            model and compares them when the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_sink;

    localparam int XS    = 8;
    localparam int YS    = 4;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = 2;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int VBP   = 1;
    localparam int HT    = XS + HFP + HSW + HBP;
    localparam int VT    = YS + VFP + VSW + VBP;
    localparam int FRAME = HT * VT * 2;
    localparam int NPIX  = XS * YS;
    localparam logic [8:0] BG = 9'b111_111_111;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic [8:0]  pix_color = '0;
    logic        pix_write = 1'b0;
    logic        busy;
    logic [15:0] drop_count;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;
    int t_cnt = 0;

    logic [8:0] model_mem [0:NPIX-1];

    typedef struct {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sb_q[$];

    vga_frame_sink #(
        .XSCREEN (XS),  .YSCREEN (YS), .BG_COLOR (BG),
        .H_FP    (HFP), .H_SYNC  (HSW), .H_BP    (HBP),
        .V_FP    (VFP), .V_SYNC  (VSW), .V_BP    (VBP)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .pix_write   (pix_write),
        .busy        (busy),
        .drop_count  (drop_count),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    always #10 Clock = ~Clock;

    function automatic logic [7:0] exp8(input logic [2:0] c);
        logic [7:0] w;
        w = {5'b0, c};
        return (w << 5) | (w << 2) | (w >> 1);
    endfunction

    // Scoreboard: push expectation for the raster position after each edge,
    // pop the one from three clocks earlier and compare with the live outputs.
    always @(posedge Clock) begin
        exp_t e;
        int p, h, v;
        logic [8:0] c;
        logic exp_clk;
        #1;
        if (Resetn !== 1'b1) begin
            t_cnt = 0;
            sb_q.delete();
        end else begin
            t_cnt++;
            p = (t_cnt / 2) % (HT * VT);
            h = p % HT;
            v = p / HT;
            e.bn = (h < XS) && (v < YS);
            e.hs = !((h >= XS + HFP) && (h < XS + HFP + HSW));
            e.vs = !((v >= YS + VFP) && (v < YS + VFP + VSW));
            if (e.bn) begin
                c = model_mem[v * XS + h];
                e.r = exp8(c[8:6]);
                e.g = exp8(c[5:3]);
                e.b = exp8(c[2:0]);
            end else begin
                e.r = 8'h00;
                e.g = 8'h00;
                e.b = 8'h00;
            end
            sb_q.push_back(e);
            if (sb_q.size() > 3) begin
                e = sb_q.pop_front();
                exp_clk = ((t_cnt - 1) % 2) == 1;
                if (mon_en) begin
                    tests++;
                    if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, VGA_R, VGA_G, VGA_B} !==
                        {e.hs, e.vs, e.bn, 1'b0, exp_clk, e.r, e.g, e.b}) begin
                        fails++;
                        $display("FAIL scan t=%0d: got hs=%b vs=%b bn=%b sn=%b clk=%b rgb=%h%h%h, expected hs=%b vs=%b bn=%b sn=0 clk=%b rgb=%h%h%h",
                                 t_cnt, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, VGA_R, VGA_G, VGA_B,
                                 e.hs, e.vs, e.bn, exp_clk, e.r, e.g, e.b);
                    end
                end
            end
        end
    end

    task automatic fill_model_bg();
        for (int i = 0; i < NPIX; i++) model_mem[i] = BG;
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        pix_write = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic wait_busy_low(output int cycles);
        cycles = 0;
        while (cycles < NPIX + 100) begin
            @(posedge Clock);
            #1;
            cycles++;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic write_pix(input int x, input int y, input logic [8:0] c);
        @(negedge Clock);
        pix_x = 10'(x);
        pix_y = 9'(y);
        pix_color = c;
        pix_write = 1'b1;
        @(negedge Clock);
        pix_write = 1'b0;
        if (x < XS && y < YS) model_mem[y * XS + x] = c;
    endtask

    task automatic drive_drops(input int n);
        @(negedge Clock);
        pix_x = 10'd1023;
        pix_y = 9'd0;
        pix_write = 1'b1;
        repeat (n) @(negedge Clock);
        pix_write = 1'b0;
    endtask

    task automatic monitor_frame();
        repeat (6) @(negedge Clock);
        mon_en = 1'b1;
        repeat (FRAME) @(negedge Clock);
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b, expected 1", busy); end
        tests++;
        if (drop_count !== 16'h0000) begin fails++; $display("FAIL reset_drop: got %h, expected 0000", drop_count); end
        tests++;
        if ({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B} !== {5'b01100, 24'h0}) begin
            fails++;
            $display("FAIL reset_vga: got clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h%h%h, expected 0 1 1 0 0 000000",
                     VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B);
        end
    endtask

    task automatic test_clear();
        int cyc;
        release_reset();
        wait_busy_low(cyc);
        tests++;
        if (cyc !== NPIX || busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_len: got %0d cycles busy=%b, expected %0d busy=0", cyc, busy, NPIX);
        end
        tests++;
        if (drop_count !== 16'h0) begin fails++; $display("FAIL clear_drop: got %h, expected 0000", drop_count); end
        fill_model_bg();
    endtask

    task automatic test_first_frame();
        monitor_frame();
    endtask

    task automatic test_corner_writes();
        logic prev_vs;
        logic [23:0] last_rgb;
        int n;
        write_pix(0, 0, 9'b111_000_000);
        write_pix(XS - 1, YS - 1, 9'b000_000_111);
        prev_vs = VGA_VS;
        n = 0;
        while (n < 2 * FRAME) begin
            @(posedge Clock); #1; n++;
            if (prev_vs && !VGA_VS) break;
            prev_vs = VGA_VS;
        end
        n = 0;
        while (n < FRAME && VGA_BLANK_N !== 1'b1) begin
            @(posedge Clock); #1; n++;
        end
        tests++;
        if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hFF0000}) begin
            fails++;
            $display("FAIL first_pixel: got bn=%b rgb=%h%h%h, expected bn=1 rgb=ff0000", VGA_BLANK_N, VGA_R, VGA_G, VGA_B);
        end
        last_rgb = 24'hxxxxxx;
        prev_vs = VGA_VS;
        n = 0;
        while (n < FRAME + 10) begin
            @(posedge Clock); #1; n++;
            if (prev_vs && !VGA_VS) break;
            prev_vs = VGA_VS;
            if (VGA_BLANK_N === 1'b1) last_rgb = {VGA_R, VGA_G, VGA_B};
        end
        tests++;
        if (last_rgb !== 24'h0000FF) begin
            fails++;
            $display("FAIL last_pixel: got rgb=%h, expected 0000ff", last_rgb);
        end
    endtask

    task automatic test_drops();
        write_pix(XS, 0, 9'b010_101_010);
        write_pix(0, YS, 9'b010_101_010);
        write_pix(1023, 511, 9'b010_101_010);
        write_pix(XS - 1, 0, 9'b000_111_000);
        @(posedge Clock); #1;
        tests++;
        if (drop_count !== 16'd3) begin fails++; $display("FAIL drop_three: got %0d, expected 3", drop_count); end
        monitor_frame();
    endtask

    task automatic test_sync();
        logic prev_vs, prev_hs;
        int n, hs_low, vs_low, hs_falls;
        prev_vs = VGA_VS;
        n = 0;
        while (n < 2 * FRAME) begin
            @(posedge Clock); #1; n++;
            if (prev_vs && !VGA_VS) break;
            prev_vs = VGA_VS;
        end
        prev_vs = VGA_VS;
        prev_hs = VGA_HS;
        n = 0; hs_low = 0; vs_low = 0; hs_falls = 0;
        while (n < 2 * FRAME) begin
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
            @(posedge Clock); #1; n++;
            if (prev_hs && !VGA_HS) hs_falls++;
            if (prev_vs && !VGA_VS) break;
            prev_vs = VGA_VS;
            prev_hs = VGA_HS;
        end
        tests++;
        if (n !== FRAME) begin fails++; $display("FAIL frame_period: got %0d, expected %0d", n, FRAME); end
        tests++;
        if (hs_low !== VT * HSW * 2) begin fails++; $display("FAIL hs_low: got %0d, expected %0d", hs_low, VT * HSW * 2); end
        tests++;
        if (vs_low !== VSW * HT * 2) begin fails++; $display("FAIL vs_low: got %0d, expected %0d", vs_low, VSW * HT * 2); end
        tests++;
        if (hs_falls !== VT) begin fails++; $display("FAIL hs_pulses: got %0d, expected %0d", hs_falls, VT); end
    endtask

    task automatic test_saturation();
        drive_drops(65531);
        @(posedge Clock); #1;
        tests++;
        if (drop_count !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h, expected fffe", drop_count); end
        drive_drops(1);
        @(posedge Clock); #1;
        tests++;
        if (drop_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hit: got %h, expected ffff", drop_count); end
        drive_drops(100);
        @(posedge Clock); #1;
        tests++;
        if (drop_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h, expected ffff", drop_count); end
    endtask

    task automatic test_write_during_clear();
        @(negedge Clock);
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        pix_write = 1'b1;
        pix_x = 10'd0;
        pix_y = 9'd0;
        pix_color = 9'b000_000_000;
        for (int k = 1; k < NPIX; k++) begin
            @(negedge Clock);
            pix_x = (k % 2 == 0) ? 10'd0 : 10'd1023;
            pix_y = (k % 2 == 0) ? 9'd0 : 9'd511;
        end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL wdc_busy_before: got %b, expected 1", busy); end
        @(negedge Clock);
        pix_write = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL wdc_busy_after: got %b, expected 0", busy); end
        tests++;
        if (drop_count !== 16'h0) begin fails++; $display("FAIL wdc_drop: got %h, expected 0000", drop_count); end
        fill_model_bg();
        monitor_frame();
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        do_reset();
        repeat (20) @(negedge Clock);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midclr_busy: got %b, expected 1", busy); end
        release_reset();
        wait_busy_low(cyc);
        tests++;
        if (cyc !== NPIX || busy !== 1'b0) begin
            fails++;
            $display("FAIL midclr_len: got %0d cycles busy=%b, expected %0d busy=0", cyc, busy, NPIX);
        end
        fill_model_bg();
        monitor_frame();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_first_frame();
        test_corner_writes();
        test_drops();
        test_sync();
        test_saturation();
        test_write_during_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
